// File: rtl/control_plane_pkg.sv
// Shared types for the control-plane handshake engine: packet layout,
// packet/FSM enums and the control-packet builder.
package control_plane_pkg;

    localparam int PKT_W    = 32;
    localparam int ID_W     = 8;
    localparam int LEN_W    = 8;
    localparam int TYPE_LSB = 30;
    localparam int SRC_LSB  = 22;
    localparam int DST_LSB  = 14;
    localparam int LEN_LSB  = 6;

    typedef enum logic [1:0] {
        PKT_NONE  = 2'b00,
        PKT_REQ   = 2'b01,
        PKT_GRANT = 2'b10,
        PKT_DONE  = 2'b11
    } pkt_type_e;

    typedef enum logic [2:0] {
        TX_IDLE       = 3'd0,
        TX_REQ        = 3'd1,
        TX_WAIT_GRANT = 3'd2,
        TX_XFER       = 3'd3,
        TX_DONE       = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_GRANT = 2'd1,
        RX_BUSY  = 2'd2
    } rx_state_e;

    function automatic logic [PKT_W-1:0] pack_ctrl(
        input pkt_type_e         ptype,
        input logic [ID_W-1:0]   src,
        input logic [ID_W-1:0]   dst,
        input logic [LEN_W-1:0]  len
    );
        logic [PKT_W-1:0] pkt;
        pkt                    = {PKT_W{1'b0}};
        pkt[TYPE_LSB +: 2]     = ptype;
        pkt[SRC_LSB +: ID_W]   = src;
        pkt[DST_LSB +: ID_W]   = dst;
        pkt[LEN_LSB +: LEN_W]  = len;
        return pkt;
    endfunction

endpackage

// File: rtl/control_plane_tx_fsm.sv
// Transmit-side handshake: request, wait for grant with timeout, drive the
// data_plane transmit flag and announce completion.
module control_plane_tx_fsm
    import control_plane_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   own_id,
    input  logic              gpp_req_tx,
    input  logic [ID_W-1:0]   gpp_dest_id,
    input  logic [LEN_W-1:0]  gpp_tx_len,
    input  logic              grant_for_me,
    input  logic [ID_W-1:0]   pkt_src,
    input  logic              data_tx_complete_flag,
    input  logic              out_blocked,
    output logic              emit_valid,
    output logic [PKT_W-1:0]  emit_pkt,
    output logic              gpp_tx_busy,
    output logic              gpp_tx_err,
    output logic              data_tx_flag
);

    localparam int CNT_W = $clog2(GRANT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(GRANT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    tx_state_e         state_d, state_q;
    logic [ID_W-1:0]   dest_d, dest_q;
    logic [LEN_W-1:0]  len_d, len_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              busy_d, busy_q;
    logic              err_d, err_q;
    logic              flag_d, flag_q;

    assign cnt_inc_s = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, latched request fields, timeout counter and registered outputs.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        flag_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                cnt_d = CNT_ZERO;
                if (gpp_req_tx) begin
                    if ((gpp_dest_id == own_id) || (gpp_tx_len == 8'd0)) begin
                        err_d = 1'b1;
                    end else begin
                        dest_d  = gpp_dest_id;
                        len_d   = gpp_tx_len;
                        state_d = TX_REQ;
                    end
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_REQ: begin
                // A GRANT from the RX side owns the output this cycle; retry next.
                if (!out_blocked) begin
                    state_d = TX_WAIT_GRANT;
                    cnt_d   = CNT_ZERO;
                end else begin
                    state_d = TX_REQ;
                end
            end
            TX_WAIT_GRANT: begin
                if (grant_for_me && (pkt_src == dest_q)) begin
                    state_d = TX_XFER;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_inc_s >= CNT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = TX_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            TX_XFER: begin
                if (data_tx_complete_flag) begin
                    state_d = TX_DONE;
                end else begin
                    flag_d = 1'b1;
                end
            end
            TX_DONE: begin
                if (!out_blocked) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_DONE;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        busy_d = (state_d != TX_IDLE);
    end

    // Packet the TX side wants on the bus this cycle.
    always_comb begin
        emit_valid = 1'b0;
        emit_pkt   = {PKT_W{1'b0}};
        if (state_q == TX_REQ) begin
            emit_valid = 1'b1;
            emit_pkt   = pack_ctrl(PKT_REQ, own_id, dest_q, len_q);
        end else if (state_q == TX_DONE) begin
            emit_valid = 1'b1;
            emit_pkt   = pack_ctrl(PKT_DONE, own_id, dest_q, len_q);
        end else begin
            emit_valid = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= TX_IDLE;
            dest_q  <= 8'h00;
            len_q   <= 8'h00;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
        end
    end

    assign gpp_tx_busy  = busy_q;
    assign gpp_tx_err   = err_q;
    assign data_tx_flag = flag_q;

endmodule

// File: rtl/control_plane.sv
// Per-node control-plane handshake engine: RX grant FSM, output arbitration
// and the transmit FSM that drives data_plane's flags.
module control_plane
    import control_plane_pkg::*;
#(
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  node_id,
    input  logic         gpp_req_tx,
    input  logic [7:0]   gpp_dest_id,
    input  logic [7:0]   gpp_tx_len,
    output logic         gpp_tx_busy,
    output logic         gpp_tx_err,
    input  logic [31:0]  control_rx_packet,
    output logic [31:0]  control_tx_packet,
    output logic         data_tx_flag,
    input  logic         data_tx_complete_flag,
    output logic         data_rx_flag,
    input  logic         data_rx_complete_flag,
    output logic [7:0]   data_rx_src_id,
    output logic [7:0]   data_rx_len
);

    pkt_type_e         rx_type_s;
    logic [ID_W-1:0]   own_id_s, rx_src_s, rx_dst_s;
    logic [LEN_W-1:0]  rx_plen_s;
    logic              for_me_s, req_for_me_s, grant_for_me_s, grant_due_s;
    logic              tx_emit_valid_s;
    logic [PKT_W-1:0]  tx_emit_pkt_s;
    logic              unused_s;

    rx_state_e         rx_state_d, rx_state_q;
    logic [ID_W-1:0]   rx_src_d, rx_src_q;
    logic [LEN_W-1:0]  rx_len_d, rx_len_q;
    logic              rx_flag_d, rx_flag_q;
    logic [PKT_W-1:0]  pkt_d, pkt_q;

    assign own_id_s       = node_id[7:0];
    assign rx_type_s      = pkt_type_e'(control_rx_packet[TYPE_LSB +: 2]);
    assign rx_src_s       = control_rx_packet[SRC_LSB +: ID_W];
    assign rx_dst_s       = control_rx_packet[DST_LSB +: ID_W];
    assign rx_plen_s      = control_rx_packet[LEN_LSB +: LEN_W];
    assign for_me_s       = (rx_type_s != PKT_NONE) && (rx_dst_s == own_id_s);
    assign req_for_me_s   = for_me_s && (rx_type_s == PKT_REQ);
    assign grant_for_me_s = for_me_s && (rx_type_s == PKT_GRANT);
    assign grant_due_s    = (rx_state_q == RX_GRANT);
    assign unused_s       = ^{node_id[15:8], control_rx_packet[5:0]};

    control_plane_tx_fsm #(
        .GRANT_TIMEOUT (GRANT_TIMEOUT)
    ) u_tx_fsm (
        .clk                   (clk),
        .rst                   (rst),
        .own_id                (own_id_s),
        .gpp_req_tx            (gpp_req_tx),
        .gpp_dest_id           (gpp_dest_id),
        .gpp_tx_len            (gpp_tx_len),
        .grant_for_me          (grant_for_me_s),
        .pkt_src               (rx_src_s),
        .data_tx_complete_flag (data_tx_complete_flag),
        .out_blocked           (grant_due_s),
        .emit_valid            (tx_emit_valid_s),
        .emit_pkt              (tx_emit_pkt_s),
        .gpp_tx_busy           (gpp_tx_busy),
        .gpp_tx_err            (gpp_tx_err),
        .data_tx_flag          (data_tx_flag)
    );

    // RX FSM: answer a REQ with a GRANT, then hold the receive flag until done.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_src_d   = rx_src_q;
        rx_len_d   = rx_len_q;
        rx_flag_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (req_for_me_s) begin
                    rx_src_d   = rx_src_s;
                    rx_len_d   = rx_plen_s;
                    rx_state_d = RX_GRANT;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_GRANT: begin
                rx_state_d = RX_BUSY;
            end
            RX_BUSY: begin
                // Further REQs are dropped here; the requester times out on its own.
                if (data_rx_complete_flag) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_flag_d = 1'b1;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Output arbitration: GRANT wins, TX packet otherwise, zeros when idle.
    always_comb begin
        if (grant_due_s) begin
            pkt_d = pack_ctrl(PKT_GRANT, own_id_s, rx_src_q, rx_len_q);
        end else if (tx_emit_valid_s) begin
            pkt_d = tx_emit_pkt_s;
        end else begin
            pkt_d = {PKT_W{1'b0}};
        end
    end

    // RX state and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_src_q   <= 8'h00;
            rx_len_q   <= 8'h00;
            rx_flag_q  <= 1'b0;
            pkt_q      <= 32'h0000_0000;
        end else begin
            rx_state_q <= rx_state_d;
            rx_src_q   <= rx_src_d;
            rx_len_q   <= rx_len_d;
            rx_flag_q  <= rx_flag_d;
            pkt_q      <= pkt_d;
        end
    end

    assign control_tx_packet = pkt_q;
    assign data_rx_flag      = rx_flag_q;
    assign data_rx_src_id    = rx_src_q;
    assign data_rx_len       = rx_len_q;

endmodule

// File: tb/tb_control_plane.sv
// Scoreboard bench for control_plane: stimulus queues expected packets and
// error pulses with their cycle; a negedge monitor pops and compares them.
module tb_control_plane;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] node_id = 16'h0003;
    logic        gpp_req_tx = 1'b0;
    logic [7:0]  gpp_dest_id = 8'h00;
    logic [7:0]  gpp_tx_len = 8'h00;
    logic        gpp_tx_busy, gpp_tx_err;
    logic [31:0] control_rx_packet = 32'h0;
    logic [31:0] control_tx_packet;
    logic        data_tx_flag;
    logic        data_tx_complete_flag = 1'b0;
    logic        data_rx_flag;
    logic        data_rx_complete_flag = 1'b0;
    logic [7:0]  data_rx_src_id, data_rx_len;

    typedef struct {
        logic [31:0] pkt;
        int          cyc;
    } exp_t;

    exp_t pkt_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t e;
    int   ec;

    control_plane #(.GRANT_TIMEOUT(TO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .node_id               (node_id),
        .gpp_req_tx            (gpp_req_tx),
        .gpp_dest_id           (gpp_dest_id),
        .gpp_tx_len            (gpp_tx_len),
        .gpp_tx_busy           (gpp_tx_busy),
        .gpp_tx_err            (gpp_tx_err),
        .control_rx_packet     (control_rx_packet),
        .control_tx_packet     (control_tx_packet),
        .data_tx_flag          (data_tx_flag),
        .data_tx_complete_flag (data_tx_complete_flag),
        .data_rx_flag          (data_rx_flag),
        .data_rx_complete_flag (data_rx_complete_flag),
        .data_rx_src_id        (data_rx_src_id),
        .data_rx_len           (data_rx_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_pkt(input logic [31:0] p, input int c);
        exp_t x;
        x.pkt = p;
        x.cyc = c;
        pkt_q.push_back(x);
    endtask

    // Monitor: every nonzero packet and every error pulse must be expected.
    always @(negedge clk) begin
        if (rst) begin
            if (control_tx_packet != 32'h0) begin
                n_cmp++;
                if (pkt_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pkt_unexpected: got %h at cycle %0d, required none", control_tx_packet, cyc);
                end else begin
                    e = pkt_q.pop_front();
                    if (e.pkt !== control_tx_packet || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL pkt: got %h at cycle %0d, required %h at cycle %0d", control_tx_packet, cyc, e.pkt, e.cyc);
                    end
                end
            end else if (pkt_q.size() != 0 && pkt_q[0].cyc < cyc) begin
                n_cmp++;
                n_fail++;
                e = pkt_q.pop_front();
                $display("FAIL pkt_missing: got none by cycle %0d, required %h at cycle %0d", cyc, e.pkt, e.cyc);
            end
            if (gpp_tx_err) begin
                n_cmp++;
                if (err_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: got pulse at cycle %0d, required none", cyc);
                end else begin
                    ec = err_q.pop_front();
                    if (ec != cyc) begin
                        n_fail++;
                        $display("FAIL err_cycle: got pulse at cycle %0d, required cycle %0d", cyc, ec);
                    end
                end
            end else if (err_q.size() != 0 && err_q[0] < cyc) begin
                n_cmp++;
                n_fail++;
                ec = err_q.pop_front();
                $display("FAIL err_missing: got none by cycle %0d, required pulse at cycle %0d", cyc, ec);
            end
        end
    end

    // Full transmit: request, grant from the destination, completion, DONE.
    task automatic tx_transfer(input logic [7:0] dst, input logic [7:0] len,
                               input logic [31:0] req_p, input logic [31:0] grant_p,
                               input logic [31:0] done_p);
        int s, c;
        @(negedge clk);
        gpp_req_tx = 1'b1; gpp_dest_id = dst; gpp_tx_len = len;
        s = cyc + 1;
        push_pkt(req_p, s + 1);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        check("tx_busy_rise", {31'h0, gpp_tx_busy}, 32'h1);
        @(negedge clk);
        control_rx_packet = grant_p;
        @(negedge clk);
        control_rx_packet = 32'h0;
        check("tx_flag_not_yet", {31'h0, data_tx_flag}, 32'h0);
        @(negedge clk);
        check("tx_flag_rise", {31'h0, data_tx_flag}, 32'h1);
        @(negedge clk);
        check("tx_flag_hold", {31'h0, data_tx_flag}, 32'h1);
        data_tx_complete_flag = 1'b1;
        c = cyc + 1;
        push_pkt(done_p, c + 1);
        @(negedge clk);
        data_tx_complete_flag = 1'b0;
        check("tx_flag_fall", {31'h0, data_tx_flag}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("tx_busy_fall", {31'h0, gpp_tx_busy}, 32'h0);
    endtask

    initial begin
        int s;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pkt", control_tx_packet, 32'h0);
        check("rst_flags", {27'h0, gpp_tx_busy, gpp_tx_err, data_tx_flag, data_rx_flag, 1'b0}, 32'h0);
        check("rst_rx_id", {16'h0, data_rx_src_id, data_rx_len}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Basic TX: node 3 -> node 5, len 10
        tx_transfer(8'd5, 8'd10, 32'h40C1_4280, 32'h8140_C280, 32'hC0C1_4280);

        // Timeout with stray grants that must be ignored
        @(negedge clk);
        gpp_req_tx = 1'b1; gpp_dest_id = 8'd9; gpp_tx_len = 8'd2;
        s = cyc + 1;
        push_pkt(32'h40C2_4080, s + 1);
        err_q.push_back(s + 1 + TO);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        @(negedge clk);
        control_rx_packet = 32'h8180_C280;
        @(negedge clk);
        control_rx_packet = 32'h8241_0080;
        @(negedge clk);
        control_rx_packet = 32'h0;
        check("to_busy_wait", {31'h0, gpp_tx_busy}, 32'h1);
        repeat (8) @(negedge clk);
        check("to_busy_idle", {31'h0, gpp_tx_busy}, 32'h0);
        check("to_no_flag", {31'h0, data_tx_flag}, 32'h0);

        // Basic RX: REQ from 7, len 4; a second REQ while busy is dropped
        @(negedge clk);
        control_rx_packet = 32'h41C0_C100;
        s = cyc + 1;
        push_pkt(32'h80C1_C100, s + 1);
        @(negedge clk);
        control_rx_packet = 32'h0;
        @(negedge clk);
        control_rx_packet = 32'h4200_C040;
        @(negedge clk);
        control_rx_packet = 32'h0;
        check("rx_flag_rise", {31'h0, data_rx_flag}, 32'h1);
        check("rx_src", {24'h0, data_rx_src_id}, 32'd7);
        check("rx_len", {24'h0, data_rx_len}, 32'd4);
        data_rx_complete_flag = 1'b1;
        @(negedge clk);
        data_rx_complete_flag = 1'b0;
        check("rx_flag_fall", {31'h0, data_rx_flag}, 32'h0);
        repeat (2) @(negedge clk);

        // Collision: own REQ and incoming REQ sampled together
        gpp_req_tx = 1'b1; gpp_dest_id = 8'd5; gpp_tx_len = 8'd10;
        control_rx_packet = 32'h41C0_C100;
        s = cyc + 1;
        push_pkt(32'h80C1_C100, s + 1);
        push_pkt(32'h40C1_4280, s + 2);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        control_rx_packet = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("col_rx_flag", {31'h0, data_rx_flag}, 32'h1);
        control_rx_packet = 32'h8140_C280;
        @(negedge clk);
        control_rx_packet = 32'h0;
        data_rx_complete_flag = 1'b1;
        @(negedge clk);
        data_rx_complete_flag = 1'b0;
        check("col_tx_flag", {31'h0, data_tx_flag}, 32'h1);
        check("col_rx_clear", {31'h0, data_rx_flag}, 32'h0);
        data_tx_complete_flag = 1'b1;
        push_pkt(32'hC0C1_4280, cyc + 2);
        @(negedge clk);
        data_tx_complete_flag = 1'b0;
        repeat (2) @(negedge clk);

        // Illegal requests: destination is self, then zero length
        gpp_req_tx = 1'b1; gpp_dest_id = 8'd3; gpp_tx_len = 8'd5;
        err_q.push_back(cyc + 1);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        check("ill_self_busy", {31'h0, gpp_tx_busy}, 32'h0);
        @(negedge clk);
        gpp_req_tx = 1'b1; gpp_dest_id = 8'd5; gpp_tx_len = 8'd0;
        err_q.push_back(cyc + 1);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        check("ill_len0_busy", {31'h0, gpp_tx_busy}, 32'h0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a transfer
        gpp_req_tx = 1'b1; gpp_dest_id = 8'd5; gpp_tx_len = 8'd10;
        s = cyc + 1;
        push_pkt(32'h40C1_4280, s + 1);
        @(negedge clk);
        gpp_req_tx = 1'b0;
        @(negedge clk);
        control_rx_packet = 32'h8140_C280;
        @(negedge clk);
        control_rx_packet = 32'h0;
        @(negedge clk);
        check("mid_tx_flag", {31'h0, data_tx_flag}, 32'h1);
        rst = 1'b0;
        #1;
        check("arst_flag", {31'h0, data_tx_flag}, 32'h0);
        check("arst_busy", {31'h0, gpp_tx_busy}, 32'h0);
        check("arst_pkt", control_tx_packet, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tx_transfer(8'd6, 8'd3, 32'h40C1_80C0, 32'h8180_C0C0, 32'hC0C1_80C0);

        repeat (4) @(negedge clk);
        check("pkt_q_drained", pkt_q.size(), 32'd0);
        check("err_q_drained", err_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion before 200000");
        $fatal(1);
    end

endmodule

// File: doc/control_plane.md
# control_plane

Per-node control-plane handshake engine for the photonic interconnect. It sits beside `data_plane` and drives that block's flags. On the transmit side it asks a remote node for permission, raises `data_tx_flag` once permission arrives, and announces completion when `data_tx_complete_flag` pulses. On the receive side it answers incoming requests with a grant, raises `data_rx_flag`, and frees itself when `data_rx_complete_flag` pulses.

## Interface
Parameters:
- `GRANT_TIMEOUT`, default 64: cycles spent in WAIT_GRANT before the request is abandoned.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `node_id`  in  16  own node id (shortint); only bits [7:0] are used in packets.
- `gpp_req_tx`  in  1  one-cycle request from the GPP to start a transfer.
- `gpp_dest_id`  in  8  destination node; sampled with `gpp_req_tx`.
- `gpp_tx_len`  in  8  word count; sampled with `gpp_req_tx`.
- `gpp_tx_busy`  out  1  high while the TX FSM is not IDLE.
- `gpp_tx_err`  out  1  one-cycle pulse on timeout or an illegal request.
- `control_rx_packet`  in  32  incoming control packet, one cycle per packet.
- `control_tx_packet`  out  32  outgoing control packet; all zeros when idle.
- `data_tx_flag`  out  1  tells `data_plane` to transmit.
- `data_tx_complete_flag`  in  1  one-cycle pulse from `data_plane`.
- `data_rx_flag`  out  1  tells `data_plane` to expect data.
- `data_rx_complete_flag`  in  1  one-cycle pulse from `data_plane`.
- `data_rx_src_id`  out  8  source of the current incoming transfer.
- `data_rx_len`  out  8  length of the current incoming transfer.

## Operation
Packet format:
- [31:30] type: 00 NONE, 01 REQ, 10 GRANT, 11 DONE.
- [29:22] source id; [21:14] destination id; [13:6] length; [5:0] zero.
- A packet is "for me" when its type is not NONE and its destination equals `node_id[7:0]`.

TX FSM (IDLE, REQ, WAIT_GRANT, XFER, DONE):
- IDLE:
  - `gpp_req_tx` latches `gpp_dest_id` and `gpp_tx_len`, then goes to REQ.
  - If the destination equals own id, or the length is 0: pulse `gpp_tx_err` and stay in IDLE.
- REQ: emit REQ{own, dest, len} for one cycle, then go to WAIT_GRANT.
- WAIT_GRANT:
  - A GRANT for me whose source equals the latched destination goes to XFER.
  - When the counter reaches `GRANT_TIMEOUT`: pulse `gpp_tx_err` and go to IDLE.
  - Any other packet is ignored.
- XFER: `data_tx_flag`=1 until `data_tx_complete_flag`, then go to DONE.
- DONE: emit DONE{own, dest, len} for one cycle, then go to IDLE.
- `gpp_req_tx` is ignored in every state except IDLE.

RX FSM (IDLE, GRANT, BUSY):
- IDLE: a REQ for me latches its source and length into `data_rx_src_id`/`data_rx_len`, then goes to GRANT.
- GRANT: emit GRANT{own, src, len} for one cycle, then go to BUSY.
- BUSY:
  - `data_rx_flag`=1 until `data_rx_complete_flag`, then go to IDLE.
  - REQs received here are dropped; the requester times out.
  - An incoming DONE is informational only and is ignored.

Output arbitration:
- If RX GRANT and TX REQ/DONE are due in the same cycle, GRANT goes first.
- The TX FSM then holds in REQ/DONE and emits one cycle later.
- The WAIT_GRANT counter starts only after REQ has actually been emitted.

## Timing
- Reset values: every output is 0, `control_tx_packet`=32'h0, both FSMs in IDLE, counter 0.
- Reset asserted mid-operation aborts everything immediately; flags drop without any DONE being sent.
- All outputs are registered.
- REQ appears on `control_tx_packet` 1 cycle after `gpp_req_tx` is sampled (2 cycles if it collides with a GRANT).
- `data_tx_flag` rises 1 cycle after the matching GRANT is sampled.
- DONE appears 1 cycle after the flag falls. The flag falls the cycle after `data_tx_complete_flag` is sampled.
- GRANT appears 1 cycle after a REQ is sampled. `data_rx_flag` rises the cycle after GRANT.
- Timeout: `gpp_tx_err` pulses exactly `GRANT_TIMEOUT` cycles after the REQ cycle when no grant arrives.
- Counter width is $clog2(GRANT_TIMEOUT)+1 and it saturates, never wraps.
- `gpp_tx_busy` is high from the cycle after the accepted request through the DONE cycle inclusive.
- A REQ and a GRANT may arrive in the same cycle only as one packet. If a GRANT matches and `data_tx_complete_flag` pulses in that same cycle, the pulse is ignored: XFER is not yet entered.

## Structure
- `control_plane_pkg` holds:
  - the packet-type enum;
  - field position and width localparams;
  - the TX and RX state enums;
  - a `pack_ctrl(type, src, dst, len)` function.
- One sub-module is natural: `control_plane_tx_fsm`, holding the TX FSM and the timeout counter.
- The RX FSM and output arbitration stay in the top level.

## Test plan
- Basic TX:
  - Stimulus: node 3, `gpp_req_tx`, dest 5, len 10.
  - Response: REQ 32'h40C1_4280 one cycle later.
  - Then inject GRANT src 5, dst 3 (len 10): `data_tx_flag` rises.
  - Then pulse complete: DONE 32'hC0C1_4280 is emitted and busy drops.
- Timeout: `GRANT_TIMEOUT`=8 and no grant -> `gpp_tx_err` pulses 8 cycles after REQ; FSM back in IDLE.
- Basic RX: REQ src 7, dst 3, len 4 -> GRANT to 7 next cycle, `data_rx_flag`=1, `data_rx_src_id`=7; complete pulse -> flag clears.
- Collision: own REQ due in the same cycle as an incoming REQ -> GRANT emitted first, own REQ the next cycle.
- Illegal requests: dest==own id, or len 0 -> single `gpp_tx_err` pulse and no packet emitted.
- Reset mid-XFER: drop `rst` while `data_tx_flag`=1 -> all outputs 0 asynchronously; after release, a new request works.
